cnn_stream_driver: RTL

//  Transmit-side sequencer for the two-layer CNN top (Top_layer). Holds one image

---
 rtl/cnn_stream_driver.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_stream_driver.sv
// cnn_stream_driver: transmit-side sequencer for the two-layer CNN receiver.
// Holds an image window plus layer-1 and layer-2 filters in local register
// files and, on go, replays them as the cycle-exact layer-1 stream, layer-1
// read window, layer-2 stream and layer-2 read window, then pulses done.
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   cfg_we/sel/addr/data register-file write port (IDLE only)
//   go                  start request, sampled in IDLE and DONE
//   busy, done          sequence status
//   Start1/Image/Filter1/ReadEn1  layer-1 stream and read enable
//   Start2/Filter2/ReadEn2        layer-2 stream and read enable
module cnn_stream_driver #(
  parameter int unsigned N_TAPS  = 15,
  parameter int unsigned IMG_W   = 4,
  parameter int unsigned F1_W    = 4,
  parameter int unsigned F2_W    = 10,
  parameter int unsigned L1_WAIT = 2,
  parameter int unsigned RD_CYC  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [3:0]        cfg_addr,
  input  logic [F2_W-1:0]   cfg_data,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              Start1,
  output logic [IMG_W-1:0]  Image,
  output logic [F1_W-1:0]   Filter1,
  output logic              ReadEn1,
  output logic              Start2,
  output logic [F2_W-1:0]   Filter2,
  output logic              ReadEn2
);

  localparam int unsigned AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int unsigned MAX_A = (N_TAPS > L1_WAIT) ? N_TAPS : L1_WAIT;
  localparam int unsigned MAX_C = (MAX_A > RD_CYC) ? MAX_A : RD_CYC;
  localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_STRM = 3'd1,
    S_L1_GAP  = 3'd2,
    S_L1_RD   = 3'd3,
    S_L2_STRM = 3'd4,
    S_L2_GAP  = 3'd5,
    S_L2_RD   = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [IMG_W-1:0]  img_q [N_TAPS];
  logic [F1_W-1:0]   f1_q  [N_TAPS];
  logic [F2_W-1:0]   f2_q  [N_TAPS];

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start1_q, start1_d;
  logic [IMG_W-1:0]  image_q, image_d;
  logic [F1_W-1:0]   filter1_q, filter1_d;
  logic              re1_q, re1_d;
  logic              start2_q, start2_d;
  logic [F2_W-1:0]   filter2_q, filter2_d;
  logic              re2_q, re2_d;

  logic              cfg_ok;
  logic              last_tap;

  // Writes land only while idle and only inside the tap range.
  assign cfg_ok   = cfg_we && (state_q == S_IDLE) && (32'(cfg_addr) < N_TAPS);
  assign last_tap = (32'(cnt_q) == N_TAPS - 1);

  // Next state and next registered outputs, driven from the current state so
  // each state's outputs appear on the edge after it is entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    start1_d  = 1'b0;
    image_d   = '0;
    filter1_d = '0;
    re1_d     = 1'b0;
    start2_d  = 1'b0;
    filter2_d = '0;
    re2_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_L1_STRM;
          cnt_d   = '0;
        end
      end
      S_L1_STRM: begin
        busy_d    = 1'b1;
        start1_d  = 1'b1;
        image_d   = img_q[AW'(cnt_q)];
        filter1_d = f1_q[AW'(cnt_q)];
        if (last_tap) begin
          cnt_d   = '0;
          state_d = S_L1_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_L1_GAP: begin
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_L1_RD;
      end
      S_L1_RD: begin
        busy_d = 1'b1;
        re1_d  = 1'b1;
        if (32'(cnt_q) == L1_WAIT - 1) begin
          cnt_d   = '0;
          state_d = S_L2_STRM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_L2_STRM: begin
        busy_d    = 1'b1;
        re1_d     = 1'b1;
        start2_d  = 1'b1;
        filter2_d = f2_q[AW'(cnt_q)];
        if (last_tap) begin
          cnt_d   = '0;
          state_d = S_L2_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_L2_GAP: begin
        busy_d  = 1'b1;
        re1_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_L2_RD;
      end
      S_L2_RD: begin
        busy_d = 1'b1;
        re1_d  = 1'b1;
        re2_d  = 1'b1;
        if (32'(cnt_q) == RD_CYC - 1) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        cnt_d  = '0;
        // A go seen here chains straight into the next sequence.
        state_d = go ? S_L1_STRM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, outputs and register files.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start1_q  <= 1'b0;
      image_q   <= '0;
      filter1_q <= '0;
      re1_q     <= 1'b0;
      start2_q  <= 1'b0;
      filter2_q <= '0;
      re2_q     <= 1'b0;
      for (int i = 0; i < int'(N_TAPS); i++) begin
        img_q[i] <= '0;
        f1_q[i]  <= '0;
        f2_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start1_q  <= start1_d;
      image_q   <= image_d;
      filter1_q <= filter1_d;
      re1_q     <= re1_d;
      start2_q  <= start2_d;
      filter2_q <= filter2_d;
      re2_q     <= re2_d;
      if (cfg_ok) begin
        case (cfg_sel)
          2'd0:    img_q[AW'(cfg_addr)] <= cfg_data[IMG_W-1:0];
          2'd1:    f1_q[AW'(cfg_addr)]  <= cfg_data[F1_W-1:0];
          2'd2:    f2_q[AW'(cfg_addr)]  <= cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Start1  = start1_q;
  assign Image   = image_q;
  assign Filter1 = filter1_q;
  assign ReadEn1 = re1_q;
  assign Start2  = start2_q;
  assign Filter2 = filter2_q;
  assign ReadEn2 = re2_q;

endmodule
